// File: rtl/operand_unpack_130.sv
// Drain side of the 130-bit operand stage: one stage word in, one pre-split double per beat out.
// Optional build macro UNARY_SKIP_EN: opcode 2'b11 words issue only the A beat.
module operand_unpack_130 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [129:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out,
  output logic         out_sign,
  output logic [10:0]  out_exp,
  output logic [52:0]  out_mant,
  output logic [1:0]   out_op,
  output logic         out_sel,
  output logic         out_last,
  output logic [1:0]   dbg_state
);

  // Handshake: a beat transfers on a falling edge where out_valid && out_ready;
  // a word is accepted on a falling edge where in_valid && in_ready. Outputs
  // hold stable while out_valid && !out_ready.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_t;

`ifdef UNARY_SKIP_EN
  localparam logic UNARY_EN = 1'b1;
`else
  localparam logic UNARY_EN = 1'b0;
`endif

  state_t      state, state_nxt;
  logic [63:0] hold_b;
  logic        load_word;
  logic        load_b;
  logic        final_beat;
  logic [63:0] load_data;
  logic        in_unary;

  assign dbg_state = state;
  assign in_unary  = UNARY_EN && (in[129:128] == 2'b11);

  // The beat currently shown closes the word: B always, A only for a unary word.
  assign final_beat = (state == SEND_B) ||
                      ((state == SEND_A) && UNARY_EN && (out_op == 2'b11));

  always_comb begin
    state_nxt = state;
    load_word = 1'b0;
    load_b    = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_word = 1'b1;
          state_nxt = SEND_A;
        end
      end
      SEND_A, SEND_B: begin
        if (final_beat) begin
          in_ready = out_ready;
          if (out_ready) begin
            if (in_valid) begin
              load_word = 1'b1;
              state_nxt = SEND_A;
            end else begin
              state_nxt = IDLE;
            end
          end
        end else if (out_ready) begin
          load_b    = 1'b1;
          state_nxt = SEND_B;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load_data = load_word ? in[63:0] : hold_b;

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_b    <= 64'd0;
      out_valid <= 1'b0;
      out       <= 64'd0;
      out_sign  <= 1'b0;
      out_exp   <= 11'd0;
      out_mant  <= 53'd0;
      out_op    <= 2'd0;
      out_sel   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_word || load_b) begin
        out_valid <= 1'b1;
        out       <= load_data;
        out_sign  <= load_data[63];
        out_exp   <= load_data[62:52];
        out_mant  <= {(load_data[62:52] != 11'd0), load_data[51:0]};
        out_sel   <= load_b;
      end
      if (load_word) begin
        hold_b   <= in[127:64];
        out_op   <= in[129:128];
        out_last <= in_unary;
      end else if (load_b) begin
        out_last <= 1'b1;
      end else if (state_nxt == IDLE) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_unpack_130.sv
// Randomized and directed bench for operand_unpack_130 against a beat-queue reference model.
// Build with UNARY_SKIP_EN defined to check the unary-skip variant.
module tb_operand_unpack_130;

`ifdef UNARY_SKIP_EN
  localparam bit UNARY_EN = 1'b1;
`else
  localparam bit UNARY_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [129:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out;
  logic         out_sign;
  logic [10:0]  out_exp;
  logic [52:0]  out_mant;
  logic [1:0]   out_op;
  logic         out_sel;
  logic         out_last;
  logic [1:0]   dbg_state;

  operand_unpack_130 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_sign(out_sign),
    .out_exp(out_exp), .out_mant(out_mant), .out_op(out_op), .out_sel(out_sel),
    .out_last(out_last), .dbg_state(dbg_state)
  );

  // clock / reset: DUT updates on the falling edge, bench drives and samples after the rising edge
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // expected beats: {op[1:0], sel, last, data[63:0]}
  logic [67:0] exp_q[$];
  bit          fresh;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [52:0] ref_mant(input logic [63:0] d);
    logic [52:0] m;
    m = 53'(d[51:0]);
    if (d[62:52] != 11'd0) m = m + 53'h10000000000000;
    return m;
  endfunction

  // one cycle: drive inputs, compare against the model, then advance the model
  task automatic step(input logic rst, input logic iv, input logic [129:0] w,
                      input logic ordy, output bit xfer, output bit acc);
    int          n;
    logic        ir_exp;
    logic [67:0] e;
    logic [1:0]  op;
    bit          unary;
    @(posedge clk);
    rst_n = rst; in_valid = iv; in = w; out_ready = ordy;
    #1;
    n = exp_q.size();
    ir_exp = (n == 0) || (n == 1 && ordy);
    chk("in_ready", in_ready, ir_exp);
    chk("out_valid", out_valid, n != 0);
    if (n != 0) begin
      e = exp_q[0];
      chk("out", out, e[63:0]);
      chk("out_sign", out_sign, e[63]);
      chk("out_exp", out_exp, e[62:52]);
      chk("out_mant", out_mant, ref_mant(e[63:0]));
      chk("out_op", out_op, e[67:66]);
      chk("out_sel", out_sel, e[65]);
      chk("out_last", out_last, e[64]);
    end else if (fresh) begin
      chk("reset_fields", {out, out_sign, out_exp, out_mant, out_op, out_sel, out_last}, '0);
    end
    xfer = (n != 0) && ordy && rst;
    acc  = iv && ir_exp && rst;
    if (!rst) begin
      exp_q.delete();
      fresh = 1'b1;
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (acc) begin
        op    = w[129:128];
        unary = UNARY_EN && (op == 2'b11);
        exp_q.push_back({op, 1'b0, unary, w[63:0]});
        if (!unary) exp_q.push_back({op, 1'b1, 1'b1, w[127:64]});
        fresh = 1'b0;
      end
    end
  endtask

  function automatic logic [63:0] rand_operand();
    logic [63:0] d;
    d = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: d[62:52] = 11'h000;
      1: d[62:52] = 11'h7FF;
      default: ;
    endcase
    return d;
  endfunction

  initial begin
    bit           x, a;
    int           nx, first, last, cyc, k;
    logic [129:0] w;
    logic         iv, ordy, rst;

    rst_n = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b0;
    fresh = 1'b1;
    repeat (2) @(negedge clk);

    // reset state, then a single normal word
    step(1, 0, '0, 1, x, a);
    step(1, 1, {2'b01, 64'hC000000000000000, 64'h3FF0000000000000}, 1, x, a);
    step(1, 0, '0, 1, x, a);
    chk("single_a_mant", out_mant, 53'h10000000000000);
    chk("single_a_exp", out_exp, 11'h3FF);
    step(1, 0, '0, 1, x, a);
    chk("single_b_sign_exp", {out_sign, out_exp}, {1'b1, 11'h400});
    step(1, 0, '0, 1, x, a);
    chk("single_done", out_valid, 1'b0);

    // denormal and zero operands
    step(1, 1, {2'b10, 64'h0, 64'h0000000000000001}, 1, x, a);
    step(1, 0, '0, 1, x, a);
    chk("denorm_a_mant", out_mant, 53'h1);
    step(1, 0, '0, 1, x, a);
    chk("zero_b_mant", out_mant, 53'h0);
    step(1, 0, '0, 1, x, a);

    // backpressure on beat A for five cycles, B right after release
    step(1, 1, {2'b00, 64'h400921FB54442D18, 64'hBFF8000000000000}, 0, x, a);
    repeat (5) step(1, 1, {2'b01, 64'h1, 64'h2}, 0, x, a);
    step(1, 0, '0, 1, x, a);
    step(1, 0, '0, 1, x, a);
    chk("bp_b_follows", x, 1'b1);
    step(1, 0, '0, 1, x, a);

    // three words back to back: six beats without a bubble
    nx = 0; k = 0;
    for (int i = 0; i < 7; i++) begin
      w = {2'(k), rand_operand(), rand_operand()};
      step(1, k < 3, w, 1, x, a);
      if (a) k++;
      if (x) nx++;
    end
    chk("b2b_beats", nx, 6);
    step(1, 0, '0, 1, x, a);

    // reset while B is stalled
    step(1, 1, {2'b01, 64'h7FF0000000000000, 64'h7FF8000000000001}, 1, x, a);
    step(1, 0, '0, 1, x, a);
    step(1, 0, '0, 0, x, a);
    step(0, 0, '0, 0, x, a);
    step(1, 0, '0, 1, x, a);
    step(1, 0, '0, 1, x, a);

    // four unary-opcode words back to back
    nx = 0; k = 0; first = -1; last = -1;
    for (cyc = 0; cyc < 20; cyc++) begin
      w = {2'b11, rand_operand(), rand_operand()};
      step(1, k < 4, w, 1, x, a);
      if (a) k++;
      if (x) begin
        nx++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (k == 4 && exp_q.size() == 0) break;
    end
    chk("unary_beats", nx, UNARY_EN ? 4 : 8);
    chk("unary_span", last - first + 1, UNARY_EN ? 4 : 8);

    // randomized traffic with an upstream that holds its word until accepted
    iv = 1'b0;
    w  = '0;
    for (int i = 0; i < 600; i++) begin
      if (!iv) begin
        iv = ($urandom_range(0, 3) != 0);
        w  = {2'($urandom_range(0, 3)), rand_operand(), rand_operand()};
      end
      ordy = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 99) != 0);
      step(rst, iv, w, ordy, x, a);
      if (a || !rst) iv = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_unpack_130.md
# operand_unpack_130

Reader/drain side of the 130-bit operand pipeline register. Accepts one 130-bit stage word (two IEEE-754 double operands plus a 2-bit opcode) through a valid/ready handshake. Issues the operands one per beat on a 64-bit output channel, with each beat already split into sign, 11-bit exponent and 53-bit mantissa. Sits between the operand-capture register stage and the per-core floating-point execution unit.

## Interface
Parameters:
- none; all widths are fixed at 130 / 64 / 11 / 53.

Ports:
- `clk`  in  1  clock; all state updates on the falling edge of `clk`
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  stage word on `in` is valid
- `in_ready`  out  1  block accepts `in` at this edge
- `in`  in  130  stage word: [63:0] operand A, [127:64] operand B, [129:128] opcode
- `out_valid`  out  1  beat on output channel is valid
- `out_ready`  in  1  downstream consumes the beat at this edge
- `out`  out  64  raw operand for the current beat
- `out_sign`  out  1  `out[63]`
- `out_exp`  out  11  `out[62:52]`
- `out_mant`  out  53  {hidden, `out[51:0]`}; hidden = 1 when `out_exp` != 0, else 0
- `out_op`  out  2  opcode of the word the beat belongs to
- `out_sel`  out  1  0 = operand A beat, 1 = operand B beat
- `out_last`  out  1  final beat of the word

## Operation
- The state machine has three states: IDLE, SEND_A and SEND_B. Reset forces IDLE.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - On accept (`in_valid`&&`in_ready`), the whole 130-bit word is latched into the hold register and the state moves to SEND_A.
- SEND_A:
  - `out_valid`=1, `out`=A, `out_sel`=0, `out_last`=0.
  - On `out_ready`, the state moves to SEND_B.
- SEND_B:
  - `out_valid`=1, `out`=B, `out_sel`=1, `out_last`=1.
  - On `out_ready`: if `in_valid`, the new word is latched and the state moves to SEND_A. Otherwise the state moves to IDLE.
- `in_ready` = (state==IDLE) || (state==SEND_B && `out_ready`). This is combinational from the state and `out_ready`.
- `in_ready`=0 in SEND_A, and in SEND_B while `out_ready`=0. The upstream holds the word.
- All output fields are registered and derived from the hold register. `out_op` is constant for both beats of a word.
- While `out_valid`=1 and `out_ready`=0, every output holds stable.
- Zero and denormal operands: exp=0 gives hidden bit 0, and the mantissa is passed through unchanged. Inf/NaN (exp=7FF) pass through unmodified; no classification.
- Reset mid-word: the held word is discarded, no further beat is issued, and the block returns to IDLE.

## Timing
- Reset values: `out_valid`=0, `out`=0, `out_sign`=0, `out_exp`=0, `out_mant`=0, `out_op`=0, `out_sel`=0, `out_last`=0, state IDLE. `in_ready`=1 during the cycle after reset release.
- Latency: the A beat is valid at the first falling edge after the accept edge (1 cycle). B follows 1 cycle after the A transfer if `out_ready` is held high.
- Throughput: 2 cycles per word with `out_ready`=1 and `in_valid`=1 continuously; there are no bubbles between words.
- Simultaneous B transfer and new accept at the same edge: the next output is A of the new word. A stall between the two words is illegal.
- `out_ready` may toggle freely. `in` is sampled only on the accept edge.

## Configuration
- `UNARY_SKIP_EN`
- Defined:
  - opcode 2'b11 marks a unary word. Its A beat is issued with `out_last`=1, and SEND_B is skipped.
  - On A transfer, the block behaves as SEND_B does on transfer: `in_ready` follows `out_ready` in that state, and it accepts the next word or goes to IDLE.
  - Throughput for unary words is 1 cycle per word.
- Undefined: every opcode yields two beats, and `out_last` is asserted only on B.

## Test plan
- Reset then single word:
  - Stimulus: A=64'h3FF0000000000000, B=64'hC000000000000000, op=2'b01, `out_ready`=1.
  - Beat A: sign=0, exp=11'h3FF, mant=53'h10000000000000, `out_sel`=0, `out_last`=0.
  - Beat B: sign=1, exp=11'h400, mant=53'h10000000000000, `out_last`=1. Then `out_valid`=0.
- Denormal/zero: A=64'h0000000000000001, B=64'h0 -> A mant=53'h1 with exp=0; B mant=0 with exp=0 (hidden bit 0 in both).
- Backpressure: hold `out_ready`=0 for 5 cycles during beat A -> all outputs are constant and `in_ready`=0. After release, B follows in the next cycle.
- Back-to-back: 3 words with `in_valid` and `out_ready` held high -> 6 consecutive beats with no bubble, in order A0,B0,A1,B1,A2,B2. The accept of word n+1 happens at the edge where B of word n transfers.
- Reset mid-word: assert `rst_n`=0 while in SEND_B with `out_ready`=0 -> next edge `out_valid`=0 and all outputs are 0. B is never issued.
- `UNARY_SKIP_EN` builds only: op=2'b11 words issue a single beat with `out_last`=1, and 4 back-to-back unary words complete in 4 cycles. Without the macro, the same stimulus yields 8 beats.
